// File: rtl/bids22_host_seq.sv
// Host-side sequencer for the bids22 controller: configures, locks, runs one round
// and reports the winning bid, first error or timeout.

package bids22defs;
    typedef enum logic [3:0] {
        NO_OP        = 4'd0,
        UNLOCK       = 4'd1,
        LOCK         = 4'd2,
        LOADX        = 4'd3,
        LOADY        = 4'd4,
        LOADZ        = 4'd5,
        SETMASK      = 4'd6,
        SETTIMER     = 4'd7,
        SETBIDCHARGE = 4'd8
    } opcode_t;

    typedef enum logic [2:0] {
        NOERROR            = 3'd0,
        BADKEY             = 3'd1,
        ALREADY_UNLOCKED   = 3'd2,
        CANNOT_LOCK        = 3'd3,
        ALREADY_LOCKED     = 3'd4,
        INVALID_OP         = 3'd5,
        CANNOT_UNLOCK      = 3'd6,
        INSUFFICIENT_FUNDS = 3'd7
    } err_t;
endpackage

module bids22_host_seq #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [DATAWIDTH-1:0]   cfg_X,
    input  logic [DATAWIDTH-1:0]   cfg_Y,
    input  logic [DATAWIDTH-1:0]   cfg_Z,
    input  logic [DATAWIDTH-1:0]   cfg_timer,
    input  logic [DATAWIDTH-1:0]   cfg_bidcost,
    input  logic [DATAWIDTH-1:0]   cfg_key,
    input  logic [DATAWIDTH-1:0]   cfg_round_len,
    input  logic [2:0]             cfg_mask,
    output bids22defs::opcode_t    C_op,
    output logic [DATAWIDTH-1:0]   C_data,
    output logic                   C_start,
    input  bids22defs::err_t       err,
    input  logic                   roundOver,
    input  logic [DATAWIDTH-1:0]   maxBid,
    output logic                   done_valid,
    output logic [DATAWIDTH-1:0]   done_maxBid,
    output bids22defs::err_t       done_err,
    output logic                   done_timeout
);

    localparam int unsigned DW = DATAWIDTH;

    typedef enum logic [3:0] {
        IDLE, UNLOCK, LOADX, LOADY, LOADZ, SETMASK, SETTIMER,
        SETBIDCHARGE, LOCK, START, WAITOVER, DONE
    } state_t;

    state_t              state, state_n;
    logic [DW-1:0]       cnt, cnt_n, cnt_inc, len_eff;
    logic [DW-1:0]       x_q, y_q, z_q, timer_q, bidcost_q, lockkey_q, len_q;
    logic [2:0]          mask_q;
    logic                locked_q;
    logic [DW-1:0]       key_q;
    logic                cmd_ok;
    bids22defs::opcode_t op_n;
    logic [DW-1:0]       data_n;
    logic [DW-1:0]       res_max;
    bids22defs::err_t    res_err;
    logic                res_to;

    assign cmd_ok  = (err == bids22defs::NOERROR);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + DW'(1);
    assign len_eff = (len_q == '0) ? DW'(1) : len_q;

    // Next state, counters and the completion record captured on entry to DONE
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        res_max = '0;
        res_err = bids22defs::NOERROR;
        res_to  = 1'b0;
        unique case (state)
            IDLE:         if (req_valid) state_n = locked_q ? UNLOCK : LOADX;
            UNLOCK:       state_n = LOADX;
            LOADX:        state_n = LOADY;
            LOADY:        state_n = LOADZ;
            LOADZ:        state_n = SETMASK;
            SETMASK:      state_n = SETTIMER;
            SETTIMER:     state_n = SETBIDCHARGE;
            SETBIDCHARGE: state_n = LOCK;
            LOCK: begin
                state_n = START;
                cnt_n   = '0;
            end
            START: begin
                if (cnt_inc >= len_eff) begin
                    state_n = WAITOVER;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            WAITOVER: begin
                if (roundOver) begin
                    state_n = DONE;
                    res_max = maxBid;
                end else if (cnt_inc >= DW'(TIMEOUT)) begin
                    state_n = DONE;
                    res_to  = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            DONE:         state_n = IDLE;
            default:      state_n = IDLE;
        endcase

        // Any command rejected by bids22 aborts the rest of the sequence
        if (state inside {UNLOCK, LOADX, LOADY, LOADZ, SETMASK, SETTIMER,
                          SETBIDCHARGE, LOCK} && !cmd_ok) begin
            state_n = DONE;
            cnt_n   = cnt;
            res_err = err;
        end
    end

    // Command bus for the upcoming cycle, decoded from the next state
    always_comb begin
        op_n   = bids22defs::NO_OP;
        data_n = '0;
        unique case (state_n)
            UNLOCK:       begin op_n = bids22defs::UNLOCK;       data_n = key_q; end
            LOADX:        begin op_n = bids22defs::LOADX;        data_n = (state == IDLE) ? cfg_X : x_q; end
            LOADY:        begin op_n = bids22defs::LOADY;        data_n = y_q; end
            LOADZ:        begin op_n = bids22defs::LOADZ;        data_n = z_q; end
            SETMASK:      begin op_n = bids22defs::SETMASK;      data_n = DW'(mask_q); end
            SETTIMER:     begin op_n = bids22defs::SETTIMER;     data_n = timer_q; end
            SETBIDCHARGE: begin op_n = bids22defs::SETBIDCHARGE; data_n = bidcost_q; end
            LOCK:         begin op_n = bids22defs::LOCK;         data_n = lockkey_q; end
            default:      begin op_n = bids22defs::NO_OP;        data_n = '0; end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            C_op         <= bids22defs::NO_OP;
            C_data       <= '0;
            C_start      <= 1'b0;
            done_valid   <= 1'b0;
            done_maxBid  <= '0;
            done_err     <= bids22defs::NOERROR;
            done_timeout <= 1'b0;
            locked_q     <= 1'b0;
            key_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            timer_q      <= '0;
            bidcost_q    <= '0;
            lockkey_q    <= '0;
            len_q        <= '0;
            mask_q       <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            req_ready  <= (state_n == IDLE);
            C_op       <= op_n;
            C_data     <= data_n;
            C_start    <= (state_n == START);
            done_valid <= (state_n == DONE);
            if (state_n == DONE) begin
                done_maxBid  <= res_max;
                done_err     <= res_err;
                done_timeout <= res_to;
            end
            if (state == IDLE && req_valid) begin
                x_q       <= cfg_X;
                y_q       <= cfg_Y;
                z_q       <= cfg_Z;
                timer_q   <= cfg_timer;
                bidcost_q <= cfg_bidcost;
                lockkey_q <= cfg_key;
                len_q     <= cfg_round_len;
                mask_q    <= cfg_mask;
            end
            if (state == LOCK && cmd_ok) begin
                locked_q <= 1'b1;
                key_q    <= lockkey_q;
            end
            if (state == UNLOCK && cmd_ok) locked_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bids22_host_seq.sv
// Bench for bids22_host_seq: a queue-based sequence model supplies per-cycle
// stimulus and expected outputs; literal checks pin the model.

module tb_bids22_host_seq;
    import bids22defs::*;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 20;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] cfg_X = '0, cfg_Y = '0, cfg_Z = '0, cfg_timer = '0;
    logic [DW-1:0] cfg_bidcost = '0, cfg_key = '0, cfg_round_len = '0;
    logic [2:0]    cfg_mask = '0;
    opcode_t       C_op;
    logic [DW-1:0] C_data;
    logic          C_start;
    err_t          err = NOERROR;
    logic          roundOver = 1'b0;
    logic [DW-1:0] maxBid = '0;
    logic          done_valid;
    logic [DW-1:0] done_maxBid;
    err_t          done_err;
    logic          done_timeout;

    bids22_host_seq #(.DATAWIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .cfg_X(cfg_X), .cfg_Y(cfg_Y), .cfg_Z(cfg_Z), .cfg_timer(cfg_timer),
        .cfg_bidcost(cfg_bidcost), .cfg_key(cfg_key), .cfg_round_len(cfg_round_len),
        .cfg_mask(cfg_mask), .C_op(C_op), .C_data(C_data), .C_start(C_start),
        .err(err), .roundOver(roundOver), .maxBid(maxBid), .done_valid(done_valid),
        .done_maxBid(done_maxBid), .done_err(done_err), .done_timeout(done_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        opcode_t       op;
        logic [DW-1:0] data;
        logic          start;
        logic          ready;
        logic          dv;
        logic [DW-1:0] dmax;
        err_t          derr;
        logic          dto;
        err_t          s_err;
        logic          s_ro;
        logic [DW-1:0] s_bid;
    } ent_t;

    ent_t q[$];

    int checks = 0;
    int failures = 0;

    // Model state: lock flag, stored key and the held completion record
    logic          m_locked = 1'b0;
    logic [DW-1:0] m_key = '0;
    logic [DW-1:0] md_max = '0;
    err_t          md_err = NOERROR;
    logic          md_to = 1'b0;

    // Observations used by the literal checks
    int            cyc = 0, op_cnt = 0, start_cnt = 0, dv_cnt = 0, fall_cyc = 0, gap = 0;
    logic [3:0]    first_op = '0;
    logic [DW-1:0] first_data = '0;
    logic          prev_start = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ent_t idle_ent();
        ent_t e;
        e.op = NO_OP; e.data = '0; e.start = 1'b0; e.ready = 1'b1; e.dv = 1'b0;
        e.dmax = md_max; e.derr = md_err; e.dto = md_to;
        e.s_err = NOERROR; e.s_ro = 1'b0; e.s_bid = '0;
        return e;
    endfunction

    task automatic add(input opcode_t op, input logic [DW-1:0] d, input logic st,
                       input logic dv, input err_t se, input logic ro, input logic [DW-1:0] b);
        ent_t e;
        e.op = op; e.data = d; e.start = st; e.ready = 1'b0; e.dv = dv;
        e.dmax = md_max; e.derr = md_err; e.dto = md_to;
        e.s_err = se; e.s_ro = ro; e.s_bid = b;
        q.push_back(e);
    endtask

    // Expected cycle-by-cycle trace of one sequence, starting the cycle after acceptance
    task automatic model_seq(input logic [DW-1:0] x, y, z, input logic [2:0] mask,
                             input logic [DW-1:0] timer, bidcost, key, len,
                             input opcode_t eop, input err_t ecode, input int ro_delay,
                             input logic [DW-1:0] bid, input logic ro_start);
        opcode_t       ops[$];
        logic [DW-1:0] dats[$];
        bit            abort = 0;
        err_t          code = NOERROR;
        int            rl;
        if (m_locked) begin ops.push_back(UNLOCK); dats.push_back(m_key); end
        ops.push_back(LOADX);        dats.push_back(x);
        ops.push_back(LOADY);        dats.push_back(y);
        ops.push_back(LOADZ);        dats.push_back(z);
        ops.push_back(SETMASK);      dats.push_back({29'b0, mask});
        ops.push_back(SETTIMER);     dats.push_back(timer);
        ops.push_back(SETBIDCHARGE); dats.push_back(bidcost);
        ops.push_back(LOCK);         dats.push_back(key);
        foreach (ops[k]) begin
            err_t se;
            se = (eop != NO_OP && ops[k] == eop) ? ecode : NOERROR;
            add(ops[k], dats[k], 1'b0, 1'b0, se, 1'b0, 32'h0bad);
            if (se != NOERROR) begin abort = 1; code = se; break; end
            if (ops[k] == UNLOCK) m_locked = 1'b0;
            if (ops[k] == LOCK) begin m_locked = 1'b1; m_key = key; end
        end
        if (abort) begin
            md_max = '0; md_err = code; md_to = 1'b0;
        end else begin
            rl = (len == 0) ? 1 : int'(len);
            for (int i = 0; i < rl; i++) add(NO_OP, '0, 1'b1, 1'b0, NOERROR, ro_start, 32'd99);
            for (int i = 0; ; i++) begin
                if (i == ro_delay) begin
                    add(NO_OP, '0, 1'b0, 1'b0, NOERROR, 1'b1, bid);
                    md_max = bid; md_err = NOERROR; md_to = 1'b0;
                    break;
                end
                add(NO_OP, '0, 1'b0, 1'b0, NOERROR, 1'b0, 32'h1234);
                if (i + 1 >= int'(TO)) begin
                    md_max = '0; md_err = NOERROR; md_to = 1'b1;
                    break;
                end
            end
        end
        add(NO_OP, '0, 1'b0, 1'b1, NOERROR, 1'b0, '0);
    endtask

    // Compare process: every cycle, apply the model's stimulus and check all outputs
    always @(negedge clk) begin
        ent_t e;
        if (q.size() != 0) e = q.pop_front();
        else e = idle_ent();
        err = e.s_err;
        roundOver = e.s_ro;
        maxBid = e.s_bid;
        chk("req_ready", 64'(req_ready), 64'(e.ready));
        chk("C_op", 64'(C_op), 64'(e.op));
        chk("C_data", 64'(C_data), 64'(e.data));
        chk("C_start", 64'(C_start), 64'(e.start));
        chk("done_valid", 64'(done_valid), 64'(e.dv));
        chk("done_maxBid", 64'(done_maxBid), 64'(e.dmax));
        chk("done_err", 64'(done_err), 64'(e.derr));
        chk("done_timeout", 64'(done_timeout), 64'(e.dto));
        if (C_op != NO_OP) begin
            op_cnt++;
            if (op_cnt == 1) begin first_op = C_op; first_data = C_data; end
        end
        if (C_start) start_cnt++;
        if (prev_start && !C_start) fall_cyc = cyc;
        if (done_valid) begin dv_cnt++; gap = cyc - fall_cyc; end
        prev_start = C_start;
        cyc++;
    end

    task automatic run(input logic [DW-1:0] x, y, z, input logic [2:0] mask,
                       input logic [DW-1:0] timer, bidcost, key, len,
                       input opcode_t eop, input err_t ecode, input int ro_delay,
                       input logic [DW-1:0] bid, input logic ro_start,
                       input bit poke, input bit reset_mid);
        logic was_locked;
        int   n;
        @(negedge clk);
        #1;
        cfg_X = x; cfg_Y = y; cfg_Z = z; cfg_mask = mask; cfg_timer = timer;
        cfg_bidcost = bidcost; cfg_key = key; cfg_round_len = len;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cfg_X = 32'hdead_0001; cfg_Y = 32'hdead_0002; cfg_Z = 32'hdead_0003;
        cfg_mask = 3'b010; cfg_timer = 32'hdead_0004; cfg_bidcost = 32'hdead_0005;
        cfg_key = 32'hdead_0006; cfg_round_len = 32'd9;
        op_cnt = 0; start_cnt = 0; dv_cnt = 0; gap = -1;
        was_locked = m_locked;
        model_seq(x, y, z, mask, timer, bidcost, key, len, eop, ecode, ro_delay, bid, ro_start);
        if (reset_mid) begin
            repeat (was_locked ? 2 : 1) @(posedge clk);
            #2;
            reset_n = 1'b0;
            q.delete();
            m_locked = 1'b0; m_key = '0; md_max = '0; md_err = NOERROR; md_to = 1'b0;
            #1;
            chk("midreset_C_op", 64'(C_op), 64'(NO_OP));
            chk("midreset_C_data", 64'(C_data), 64'd0);
            chk("midreset_req_ready", 64'(req_ready), 64'd1);
            chk("midreset_done_err", 64'(done_err), 64'(NOERROR));
            repeat (2) @(posedge clk);
            #2;
            reset_n = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            chk("midreset_no_done", 64'(dv_cnt), 64'd0);
        end else begin
            if (poke) begin
                repeat (10) @(posedge clk);
                #1 req_valid = 1'b1;
                repeat (3) @(posedge clk);
                #1 req_valid = 1'b0;
            end
            n = 0;
            while (q.size() != 0 && n < 1000) begin
                @(posedge clk);
                n++;
            end
            if (n >= 1000) chk("sequence_budget", 64'(n), 64'd0);
            #1;
        end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_C_op", 64'(C_op), 64'(NO_OP));
        chk("reset_C_data", 64'(C_data), 64'd0);
        chk("reset_C_start", 64'(C_start), 64'd0);
        chk("reset_done_valid", 64'(done_valid), 64'd0);
        chk("reset_done_maxBid", 64'(done_maxBid), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic sequence; roundOver during START must be ignored
        run(32'd10, 32'd20, 32'd30, 3'b111, 32'd100, 32'd2, 32'h5A, 32'd4,
            NO_OP, NOERROR, 2, 32'd7, 1'b1, 0, 0);
        chk("t1_first_op", 64'(first_op), 64'(LOADX));
        chk("t1_cmd_cycles", 64'(op_cnt), 64'd7);
        chk("t1_start_cycles", 64'(start_cnt), 64'd4);
        chk("t1_done_pulses", 64'(dv_cnt), 64'd1);
        chk("t1_done_maxBid", 64'(done_maxBid), 64'd7);
        chk("t1_done_err", 64'(done_err), 64'(NOERROR));

        // Locked: UNLOCK with the stored key precedes LOADX
        run(32'd1, 32'd2, 32'd3, 3'b001, 32'd50, 32'd1, 32'h33, 32'd2,
            NO_OP, NOERROR, 0, 32'd9, 1'b0, 0, 0);
        chk("t2_first_op", 64'(first_op), 64'(UNLOCK));
        chk("t2_first_data", 64'(first_data), 64'h5A);
        chk("t2_cmd_cycles", 64'(op_cnt), 64'd8);
        chk("t2_done_maxBid", 64'(done_maxBid), 64'd9);

        // Error during SETMASK aborts before SETTIMER
        run(32'd4, 32'd5, 32'd6, 3'b011, 32'd7, 32'd8, 32'h44, 32'd3,
            SETMASK, INVALID_OP, 0, 32'd5, 1'b0, 0, 0);
        chk("t3_cmd_cycles", 64'(op_cnt), 64'd5);
        chk("t3_done_err", 64'(done_err), 64'(INVALID_OP));
        chk("t3_done_maxBid", 64'(done_maxBid), 64'd0);
        chk("t3_start_cycles", 64'(start_cnt), 64'd0);

        // No roundOver: timeout, with req_valid poked while busy
        run(32'd11, 32'd12, 32'd13, 3'b100, 32'd14, 32'd15, 32'h77, 32'd1,
            NO_OP, NOERROR, -1, 32'd0, 1'b0, 1, 0);
        chk("t4_first_op", 64'(first_op), 64'(LOADX));
        chk("t4_gap", 64'(gap), 64'(TO));
        chk("t4_done_timeout", 64'(done_timeout), 64'd1);
        chk("t4_done_pulses", 64'(dv_cnt), 64'd1);

        // round_len 0 behaves as 1
        run(32'd21, 32'd22, 32'd23, 3'b101, 32'd24, 32'd25, 32'h42, 32'd0,
            NO_OP, NOERROR, 3, 32'd123, 1'b0, 0, 0);
        chk("t5_start_cycles", 64'(start_cnt), 64'd1);
        chk("t5_first_data", 64'(first_data), 64'h77);
        chk("t5_done_timeout", 64'(done_timeout), 64'd0);

        // Rejected UNLOCK aborts immediately
        run(32'd31, 32'd32, 32'd33, 3'b110, 32'd34, 32'd35, 32'h99, 32'd2,
            UNLOCK, BADKEY, 0, 32'd1, 1'b0, 0, 0);
        chk("t6_cmd_cycles", 64'(op_cnt), 64'd1);
        chk("t6_done_err", 64'(done_err), 64'(BADKEY));

        // Reset during LOADY, then a fresh sequence starts at LOADX
        run(32'd41, 32'd42, 32'd43, 3'b111, 32'd44, 32'd45, 32'h11, 32'd2,
            NO_OP, NOERROR, 1, 32'd2, 1'b0, 0, 1);
        run(32'd51, 32'd52, 32'd53, 3'b010, 32'd54, 32'd55, 32'h22, 32'd2,
            NO_OP, NOERROR, 1, 32'd66, 1'b0, 0, 0);
        chk("t8_first_op", 64'(first_op), 64'(LOADX));
        chk("t8_cmd_cycles", 64'(op_cnt), 64'd7);
        chk("t8_done_maxBid", 64'(done_maxBid), 64'd66);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule
